// File: rtl/tile_placer.sv
// Places one new tile (exponent 1, or 2 when TILE_FOUR_EN is defined and
// rand_bit=1) into a random empty cell of a 4x4 board of 4-bit exponents.
module tile_placer #(
    parameter int MAX_RETRY = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [63:0] i_board_in,
    input  logic        i_start,
    input  logic        i_pos_valid,
    input  logic [3:0]  i_pos,
    input  logic        i_rand_bit,
    output logic        o_pos_req,
    output logic [15:0] o_empty_mask,
    output logic [63:0] o_board_out,
    output logic [3:0]  o_placed_pos,
    output logic        o_done,
    output logic        o_full,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        REQ,
        CHECK,
        WRITE,
        FIN
    } state_t;

    localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY - 1);

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_board;
    logic [15:0] r_empty_mask;
    logic [3:0]  r_placed_pos;
    logic [3:0]  r_retry_cnt;
    logic [3:0]  r_pos;
    logic [3:0]  r_target;
    logic        r_full;

    logic [15:0] w_board_mask;
    logic [3:0]  w_lowest;
    logic        w_hit;
    logic        w_last_try;
    logic [3:0]  w_tile;

`ifdef TILE_FOUR_EN
    assign w_tile = i_rand_bit ? 4'd2 : 4'd1;
`else
    logic w_unused_rand_bit;
    assign w_unused_rand_bit = i_rand_bit;
    assign w_tile = 4'd1;
`endif

    always_comb begin
        w_board_mask = '0;
        for (int k = 0; k < 16; k++) begin
            w_board_mask[k] = (r_board[4*k +: 4] == 4'd0);
        end
    end

    // Fallback target: scanning downward leaves the lowest set bit last.
    always_comb begin
        w_lowest = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (r_empty_mask[k]) begin
                w_lowest = 4'(k);
            end
        end
    end

    assign w_hit      = r_empty_mask[r_pos];
    assign w_last_try = (r_retry_cnt == RETRY_LAST);

    always_comb begin
        w_next    = r_state;
        o_pos_req = 1'b0;
        o_done    = 1'b0;
        o_full    = 1'b0;
        o_busy    = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = SCAN;
                end
            end
            SCAN: begin
                w_next = (w_board_mask == 16'd0) ? FIN : REQ;
            end
            REQ: begin
                o_pos_req = 1'b1;
                if (i_pos_valid) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                w_next = (w_hit || w_last_try) ? WRITE : REQ;
            end
            WRITE: begin
                w_next = FIN;
            end
            FIN: begin
                o_done = 1'b1;
                o_full = r_full;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_board      <= '0;
            r_empty_mask <= '0;
            r_placed_pos <= '0;
            r_retry_cnt  <= '0;
            r_pos        <= '0;
            r_target     <= '0;
            r_full       <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (i_load && !i_start) begin
                        r_board <= i_board_in;
                    end
                end
                SCAN: begin
                    r_empty_mask <= w_board_mask;
                    r_retry_cnt  <= '0;
                    r_full       <= (w_board_mask == 16'd0);
                end
                REQ: begin
                    if (i_pos_valid) begin
                        r_pos <= i_pos;
                    end
                end
                CHECK: begin
                    if (w_hit) begin
                        r_target <= r_pos;
                    end else if (w_last_try) begin
                        r_target <= w_lowest;
                    end else begin
                        r_retry_cnt <= r_retry_cnt + 4'd1;
                    end
                end
                WRITE: begin
                    r_board[{r_target, 2'b00} +: 4] <= w_tile;
                    r_placed_pos                    <= r_target;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_empty_mask = r_empty_mask;
    assign o_board_out  = r_board;
    assign o_placed_pos = r_placed_pos;

endmodule

// File: tb/tb_tile_placer.sv
// Randomized bench for tile_placer against a cell-array model of the board;
// expected tile value follows TILE_FOUR_EN the same way as the design build.
module tb_tile_placer;

    localparam int MAXR = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_load = 1'b0;
    logic [63:0] i_board_in = '0;
    logic        i_start = 1'b0;
    logic        i_pos_valid = 1'b0;
    logic [3:0]  i_pos = '0;
    logic        i_rand_bit = 1'b0;
    logic        o_pos_req;
    logic [15:0] o_empty_mask;
    logic [63:0] o_board_out;
    logic [3:0]  o_placed_pos;
    logic        o_done;
    logic        o_full;
    logic        o_busy;

    int nTotal = 0;
    int nBad = 0;

    logic [3:0] bd[16];
    logic [3:0] expPlaced;
    int posArr[MAXR];
    int waitArr[MAXR];

    tile_placer #(.MAX_RETRY(MAXR)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_board_in(i_board_in),
        .i_start(i_start), .i_pos_valid(i_pos_valid), .i_pos(i_pos),
        .i_rand_bit(i_rand_bit), .o_pos_req(o_pos_req), .o_empty_mask(o_empty_mask),
        .o_board_out(o_board_out), .o_placed_pos(o_placed_pos), .o_done(o_done),
        .o_full(o_full), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTotal++;
        if (got !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] packBoard();
        logic [63:0] v;
        for (int k = 0; k < 16; k++) v[4*k +: 4] = bd[k];
        return v;
    endfunction

    function automatic logic [15:0] maskOf();
        logic [15:0] m;
        for (int k = 0; k < 16; k++) m[k] = (bd[k] == 4'd0);
        return m;
    endfunction

    function automatic logic [3:0] tileFor(input logic rb);
`ifdef TILE_FOUR_EN
        return rb ? 4'd2 : 4'd1;
`else
        return 4'd1;
`endif
    endfunction

    task automatic loadBoard();
        @(negedge i_clk);
        i_load = 1'b1;
        i_board_in = packBoard();
        @(negedge i_clk);
        i_load = 1'b0;
    endtask

    // Drives one placement, answering position requests from posArr/waitArr
    // and throwing ignored load/start noise at the block while it is busy.
    task automatic applyStimulus(input logic rb, input bit loadWithStart, output int lat,
                                 output int reqCount, output int reqHigh,
                                 output int doneCount, output logic fullSeen);
        int attempt;
        int waitLeft;
        bit inReq;
        bit seenDone;
        lat = -1; reqCount = 0; reqHigh = 0; doneCount = 0; fullSeen = 1'b0;
        attempt = 0; waitLeft = 0; inReq = 0; seenDone = 0;
        @(negedge i_clk);
        i_start = 1'b1;
        i_rand_bit = rb;
        i_load = loadWithStart;
        i_board_in = {16{4'h7}};
        for (int t = 1; t <= 200; t++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            i_load = 1'b0;
            i_pos_valid = 1'b0;
            if (t == 1) checkOutput("busy_in_scan", 64'(o_busy), 64'd1);
            if (o_done) begin
                doneCount++;
                if (!seenDone) begin
                    lat = t;
                    fullSeen = o_full;
                end
                seenDone = 1;
            end
            if (o_busy && !o_done && !seenDone) begin
                i_load = 1'(($urandom_range(0, 1)));
                i_start = 1'(($urandom_range(0, 1)));
                i_board_in = {$urandom, $urandom};
            end
            if (o_pos_req) begin
                reqHigh++;
                if (!inReq) begin
                    inReq = 1;
                    waitLeft = (attempt < MAXR) ? waitArr[attempt] : 0;
                end
                if (waitLeft > 0) begin
                    waitLeft--;
                end else begin
                    i_pos_valid = 1'b1;
                    i_pos = 4'((attempt < MAXR) ? posArr[attempt] : 0);
                    reqCount++;
                    attempt++;
                    inReq = 0;
                end
            end
            if (seenDone && t >= lat + 3) break;
        end
        i_start = 1'b0;
        i_load = 1'b0;
        i_pos_valid = 1'b0;
        if (!seenDone) checkOutput("timeout_no_done", 64'd0, 64'd1);
    endtask

    // Model: try each candidate in order; an empty cell wins, otherwise the
    // last allowed try falls back to the lowest-index empty cell.
    task automatic runCase(input string name, input logic rb, input bit loadWithStart);
        logic [15:0] mask;
        bit isFull;
        int target;
        int attempts;
        int expLat;
        int expReqHigh;
        int lat, reqCount, reqHigh, doneCount;
        logic fullSeen;
        loadBoard();
        mask = maskOf();
        isFull = (mask == 16'd0);
        target = 0;
        attempts = 0;
        if (!isFull) begin
            for (int a = 0; a < MAXR; a++) begin
                attempts = a + 1;
                if (bd[posArr[a]] == 4'd0) begin
                    target = posArr[a];
                    break;
                end
                if (a == MAXR - 1) begin
                    for (int k = 15; k >= 0; k--) if (bd[k] == 4'd0) target = k;
                end
            end
        end
        expReqHigh = 0;
        expLat = 2;
        if (!isFull) begin
            expLat = 3;
            for (int a = 0; a < attempts; a++) begin
                expLat += 2 + waitArr[a];
                expReqHigh += 1 + waitArr[a];
            end
        end
        applyStimulus(rb, loadWithStart, lat, reqCount, reqHigh, doneCount, fullSeen);
        if (!isFull) begin
            bd[target] = tileFor(rb);
            expPlaced = 4'(target);
        end
        checkOutput({name, "_latency"}, 64'(lat), 64'(expLat));
        checkOutput({name, "_full"}, 64'(fullSeen), 64'(isFull));
        checkOutput({name, "_done_pulses"}, 64'(doneCount), 64'd1);
        checkOutput({name, "_req_count"}, 64'(reqCount), 64'(attempts));
        checkOutput({name, "_req_high"}, 64'(reqHigh), 64'(expReqHigh));
        checkOutput({name, "_mask"}, 64'(o_empty_mask), 64'(mask));
        checkOutput({name, "_board"}, o_board_out, packBoard());
        checkOutput({name, "_placed"}, 64'(o_placed_pos), 64'(expPlaced));
    endtask

    task automatic clearPlan();
        for (int a = 0; a < MAXR; a++) begin
            posArr[a] = 0;
            waitArr[a] = 0;
        end
    endtask

    initial begin
        int pct;
        for (int k = 0; k < 16; k++) bd[k] = 4'd0;
        expPlaced = 4'd0;
        clearPlan();

        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        checkOutput("reset_board", o_board_out, 64'd0);
        checkOutput("reset_mask", 64'(o_empty_mask), 64'd0);
        checkOutput("reset_placed", 64'(o_placed_pos), 64'd0);
        checkOutput("reset_ctrl", {60'd0, o_pos_req, o_done, o_full, o_busy}, 64'd0);
        i_rst = 1'b0;

        posArr[0] = 5;
        runCase("empty_pos5", 1'b0, 1'b0);

        for (int k = 0; k < 16; k++) bd[k] = 4'd3;
        runCase("full_board", 1'b0, 1'b0);

        bd[9] = 4'd0;
        clearPlan();
        runCase("retry_fallback", 1'b0, 1'b0);

        for (int k = 0; k < 16; k++) bd[k] = 4'd0;
        clearPlan();
        waitArr[0] = 20;
        posArr[0] = 2;
        runCase("long_wait", 1'b0, 1'b0);

        for (int k = 0; k < 16; k++) bd[k] = 4'd0;
        clearPlan();
        runCase("tile_rb1", 1'b1, 1'b0);

        for (int k = 0; k < 16; k++) bd[k] = (k == 6) ? 4'd0 : 4'd2;
        clearPlan();
        posArr[1] = 6;
        runCase("start_beats_load", 1'b0, 1'b1);

        // Reset landing in CHECK must abort silently and clear the board.
        for (int k = 0; k < 16; k++) bd[k] = 4'd0;
        loadBoard();
        @(negedge i_clk);
        i_start = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            if (o_pos_req) break;
        end
        checkOutput("rst_reached_req", 64'(o_pos_req), 64'd1);
        i_pos_valid = 1'b1;
        i_pos = 4'd3;
        @(negedge i_clk);
        i_pos_valid = 1'b0;
        checkOutput("rst_in_check_state", {62'd0, o_busy, o_pos_req}, 64'd2);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        checkOutput("rst_abort_board", o_board_out, 64'd0);
        checkOutput("rst_abort_ctrl", {61'd0, o_done, o_full, o_busy}, 64'd0);
        checkOutput("rst_abort_placed", 64'(o_placed_pos), 64'd0);
        @(negedge i_clk);
        checkOutput("rst_no_late_done", 64'(o_done), 64'd0);
        expPlaced = 4'd0;
        for (int k = 0; k < 16; k++) bd[k] = 4'd1;
        bd[12] = 4'd0;
        clearPlan();
        posArr[0] = 12;
        runCase("after_reset", 1'b1, 1'b0);

        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 3))
                0: pct = 0;
                1: pct = 10;
                2: pct = 40;
                default: pct = 90;
            endcase
            for (int k = 0; k < 16; k++)
                bd[k] = ($urandom_range(0, 99) < pct) ? 4'd0 : 4'($urandom_range(1, 11));
            for (int a = 0; a < MAXR; a++) begin
                posArr[a] = $urandom_range(0, 15);
                waitArr[a] = $urandom_range(0, 3);
            end
            runCase("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule

// File: doc/tile_placer.md
TILE_PLACER -- requirements
Module: tile_placer

Interface
REQ-001 Parameter MAX_RETRY, default 4, number of occupied-cell position responses tolerated before falling back to the lowest-index empty cell; legal range 1..15.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 load  input  1  in IDLE, copy board_in into the board register.
REQ-005 board_in  input  64  16 cells x 4-bit exponent; cell k = bits [4k+3:4k]; 0 = empty.
REQ-006 start  input  1  in IDLE, begin one tile placement.
REQ-007 pos_valid  input  1  position response from the random position source.
REQ-008 pos  input  4  random candidate cell index; sampled only when pos_req and pos_valid are both high.
REQ-009 rand_bit  input  1  tile value select; sampled in the WRITE state.
REQ-010 pos_req  output  1  position request to the random source.
REQ-011 empty_mask  output  16  registered mask; bit k = 1 when cell k is 0.
REQ-012 board_out  output  64  current board register.
REQ-013 placed_pos  output  4  index of the last cell written.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 full  output  1  with done: no empty cell existed and nothing was written.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, SCAN, REQ, CHECK, WRITE, FIN.
REQ-018 In IDLE, start has priority over load when both are high in the same cycle; start SHALL go to SCAN, and load SHALL be ignored that cycle.
REQ-019 load and start outside IDLE SHALL be ignored.
REQ-020 SCAN SHALL register empty_mask from the board and clear retry_cnt; if the mask is zero, go to FIN with full=1, otherwise go to REQ.
REQ-021 In REQ, pos_req SHALL be high and SHALL stay high until pos_valid is sampled high; that edge captures pos, and the state goes to CHECK, with pos_req low in CHECK.
REQ-022 In CHECK, if empty_mask[pos] = 1, the target SHALL be pos and the state goes to WRITE.
REQ-023 In CHECK, if empty_mask[pos] = 0 and retry_cnt = MAX_RETRY-1, the target SHALL be the lowest-index set bit of empty_mask and the state goes to WRITE.
REQ-024 In CHECK, in any other case, retry_cnt SHALL increment and the state returns to REQ.
REQ-025 WRITE SHALL write the tile exponent (REQ-035/036) into the target cell, set placed_pos to the target, and go to FIN.
REQ-026 FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-027 full SHALL be valid only while done is high, and SHALL be low in any non-full FIN.
REQ-028 Latency, start high in cycle N and pos_valid already high: SCAN N+1, REQ N+2, CHECK N+3, WRITE N+4; done and the updated board_out in N+5.
REQ-029 Latency on a full board: done=1 and full=1 in N+2, board_out unchanged.
REQ-030 Each retry SHALL add 2 cycles plus the pos_valid wait.
REQ-031 placed_pos SHALL hold its value until the next WRITE.
REQ-032 empty_mask SHALL update only in SCAN.

Reset
REQ-033 When rst is high at a rising edge: state SHALL go to IDLE; board, empty_mask, placed_pos, and retry_cnt SHALL clear to 0; pos_req, done, full, and busy SHALL be 0.
REQ-034 rst mid-operation SHALL abort without a write and without a done pulse; rst SHALL have priority over all other inputs.

Configuration
REQ-035 With macro TILE_FOUR_EN defined, WRITE SHALL write exponent 2 (tile 4) when rand_bit = 1 and exponent 1 (tile 2) when rand_bit = 0.
REQ-036 Without TILE_FOUR_EN, WRITE SHALL always write exponent 1, and rand_bit SHALL be unused.

Verification
REQ-037 Empty board loaded, start, pos=5 with pos_valid held high -> done in N+5, cell 5 = 1, placed_pos=5, full=0.
REQ-038 board_in with all cells = 3, start -> done and full high in N+2, pos_req never high, board_out unchanged.
REQ-039 Only cell 9 empty, MAX_RETRY=4, pos always 0 -> 3 retries, then cell 9 written, placed_pos=9, pos_req seen high 4 times.
REQ-040 pos_valid held low 20 cycles after REQ entry, then pos=2 on empty cell -> pos_req high the whole wait, cell 2 written, one done pulse.
REQ-041 rst asserted in CHECK -> next cycle: IDLE, board all 0, no done pulse; subsequent load/start operate normally.
REQ-042 TILE_FOUR_EN defined, rand_bit=1, empty board, pos=0 -> cell 0 = 2; same run with the macro undefined -> cell 0 = 1.
